dmem_responder: RTL



---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : CPU data-port responder with a byte-lane RAM, a cycle counter and
//            a console byte FIFO behind an MMIO window.
// Option   : define DMEM_CYCLE64_EN to widen CYCLE to 64 bits (high word @0x0C)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] MMIO_TAG    = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam int          FW         = $clog2(FIFO_DEPTH);
   localparam logic [FW:0] FULL_COUNT = (FW + 1)'(FIFO_DEPTH);
   localparam logic [13:0] OFF_CYCLE  = 14'h0000;
   localparam logic [13:0] OFF_TX     = 14'h0001;
   localparam logic [13:0] OFF_STATUS = 14'h0002;
   localparam logic [13:0] OFF_CYCLEH = 14'h0003;

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [FW-1:0] r_rptr;
   logic [FW-1:0] r_wptr;
   logic [FW:0]   r_count;
   logic          r_ovf;
`ifdef DMEM_CYCLE64_EN
   logic [63:0]   r_cycle;
`else
   logic [31:0]   r_cycle;
`endif

   logic          w_is_mmio;
   logic [13:0]   w_off;
   logic [AW-1:0] w_idx;
   logic          w_tx_wr;
   logic          w_st_wr;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [7:0]    w_count8;
   logic [31:0]   w_status;
   logic [31:0]   w_cycle_lo;
   logic [31:0]   w_cycle_hi;
   logic          w_unused;

   // ------------------------------------------------------------------------
   // Address decode; the CPU already lane-aligns, so daddr[1:0] is dropped
   // ------------------------------------------------------------------------
   assign w_is_mmio = (daddr[31:16] == MMIO_TAG);
   assign w_off     = daddr[15:2];
   assign w_idx     = daddr[AW+1:2];
   assign w_unused  = ^daddr[1:0];

   assign w_tx_wr   = w_is_mmio && (w_off == OFF_TX) && dwe[0];
   assign w_st_wr   = w_is_mmio && (w_off == OFF_STATUS) && dwe[0];

   // ------------------------------------------------------------------------
   // Word RAM: contents survive reset, writes are blocked while it is held
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset && !w_is_mmio) begin
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) begin
               r_mem[w_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output FIFO; a push into a full FIFO is accepted if a pop frees a slot
   // ------------------------------------------------------------------------
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_COUNT);
   assign w_pop   = !w_empty && out_ready;
   assign w_push  = w_tx_wr && (!w_full || w_pop);
   assign w_drop  = w_tx_wr && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_fifo[r_wptr] <= dwdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // An overflowing push outranks a same-cycle clear
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_st_wr && dwdata[2]) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign out_valid = !w_empty;
   assign out_data  = r_fifo[r_rptr];

   // ------------------------------------------------------------------------
   // Free-running cycle counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle <= '0;
      end else begin
         r_cycle <= r_cycle + 1'b1;
      end
   end

   assign w_cycle_lo = r_cycle[31:0];
`ifdef DMEM_CYCLE64_EN
   assign w_cycle_hi = r_cycle[63:32];
`else
   assign w_cycle_hi = 32'h0;
`endif

   // ------------------------------------------------------------------------
   // Combinational read mux
   // ------------------------------------------------------------------------
   assign w_count8 = 8'(r_count);
   assign w_status = {16'h0, w_count8, 5'b0, r_ovf, w_full, w_empty};

   always_comb begin
      drdata = 32'h0;
      if (!w_is_mmio) begin
         drdata = r_mem[w_idx];
      end else begin
         case (w_off)
            OFF_CYCLE:  drdata = w_cycle_lo;
            OFF_STATUS: drdata = w_status;
            OFF_CYCLEH: drdata = w_cycle_hi;
            default:    drdata = 32'h0;
         endcase
      end
   end

endmodule
`default_nettype wire
